// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Requester encoding doubles as the round-robin pointer encoding.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
    logic                  is_byte;
  } wr_req_t;

  // The pointer names the side that wins the next contested cycle.
  typedef enum logic {
    GRANT_ALU_FIRST = REQ_ALU,
    GRANT_MEM_FIRST = REQ_MEM
  } rr_state_e;

endpackage

// File: rtl/rf_req_fifo.sv
// Small per-requester write-request FIFO. Besides the head it exposes a
// per-slot valid/register view so the owner can scan for pending writes.
module rf_req_fifo
  import regfile_pkg::*;
#(
  parameter int  DEPTH  = 2,
  parameter int  ADDR_W = DEF_ADDR_W,
  parameter type entry_t = wr_req_t
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          push,
  input  entry_t                        push_entry,
  input  logic                          pop,
  output entry_t                        head,
  output logic                          empty,
  output logic                          full,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_reg
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               do_push, do_pop;
  logic [PTR_W-1:0]   offset;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem_q[rd_ptr_q];

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first); a missed branch would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_comb begin
    ent_valid = '0;
    ent_reg   = '0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PTR_W'(i) - rd_ptr_q;
      ent_valid[i] = ({1'b0, offset} < count_q);
      ent_reg[i]   = mem_q[i].rd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; slots are only observed through ent_valid
  // and the count, which are reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between ALU write-back and
// memory return, with per-requester FIFOs, round-robin arbitration and a RAW stall.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_byte,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_byte,
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  output logic              regWrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              byteOperations,
  output logic              stall,
  output logic              idle,
  output logic [15:0]       wr_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              is_byte;
  } req_t;

  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_ZERO);

  req_t alu_in, mem_in, alu_head, mem_head, grant_entry;
  logic alu_empty, alu_full, mem_empty, mem_full;
  logic alu_push, mem_push, alu_pop, mem_pop;
  logic grant_alu, grant_mem, grant_any, contested;
  logic [FIFO_DEPTH-1:0]             alu_ev, mem_ev;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] alu_er, mem_er;

  rr_state_e         rr_q, rr_d;
  logic              en_q, en_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              byte_q, byte_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic              hit1, hit2;

  assign alu_in = '{rd: alu_reg, data: alu_data, is_byte: alu_byte};
  assign mem_in = '{rd: mem_reg, data: mem_data, is_byte: mem_byte};

  // Readiness is the registered full flag, held low until the first edge after reset.
  assign alu_ready = en_q && !alu_full;
  assign mem_ready = en_q && !mem_full;
  assign alu_push  = alu_valid && alu_ready && !flush;
  assign mem_push  = mem_valid && mem_ready && !flush;

  rf_req_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .entry_t(req_t)) u_alu_fifo (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push(alu_push), .push_entry(alu_in), .pop(alu_pop),
    .head(alu_head), .empty(alu_empty), .full(alu_full),
    .ent_valid(alu_ev), .ent_reg(alu_er)
  );

  rf_req_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .entry_t(req_t)) u_mem_fifo (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push(mem_push), .push_entry(mem_in), .pop(mem_pop),
    .head(mem_head), .empty(mem_empty), .full(mem_full),
    .ent_valid(mem_ev), .ent_reg(mem_er)
  );

  assign contested   = !alu_empty && !mem_empty;
  assign grant_mem   = !mem_empty && (alu_empty || rr_q == GRANT_MEM_FIRST);
  assign grant_alu   = !alu_empty && !grant_mem;
  assign grant_any   = grant_alu || grant_mem;
  assign grant_entry = grant_mem ? mem_head : alu_head;
  assign alu_pop     = grant_alu && !flush;
  assign mem_pop     = grant_mem && !flush;

  always_comb begin
    en_d         = 1'b1;
    rr_d         = rr_q;
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    byte_d       = byte_q;
    if (flush) begin
      rr_d = GRANT_ALU_FIRST;
    end else if (grant_any) begin
      // r0 writes still pop and update the bus, but never strobe.
      regwrite_d   = (grant_entry.rd != ZERO_REG);
      write_reg_d  = grant_entry.rd;
      write_data_d = grant_entry.data;
      byte_d       = grant_entry.is_byte;
      if (contested) rr_d = (rr_q == GRANT_ALU_FIRST) ? GRANT_MEM_FIRST : GRANT_ALU_FIRST;
    end
  end

  // A strobe is counted at the edge that ends its cycle, so one already on the bus when flush arrives still counts.
  always_comb begin
    wr_count_d = wr_count_q;
    if (regwrite_q && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q         <= 1'b0;
      rr_q         <= GRANT_ALU_FIRST;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      byte_q       <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      en_q         <= en_d;
      rr_q         <= rr_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      byte_q       <= byte_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Pending-write scoreboard: queued entries plus the strobe on the bus.
  always_comb begin
    hit1 = regwrite_q && (write_reg_q == rd_reg1);
    hit2 = regwrite_q && (write_reg_q == rd_reg2);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((alu_ev[i] && alu_er[i] == rd_reg1) || (mem_ev[i] && mem_er[i] == rd_reg1)) hit1 = 1'b1;
      if ((alu_ev[i] && alu_er[i] == rd_reg2) || (mem_ev[i] && mem_er[i] == rd_reg2)) hit2 = 1'b1;
    end
  end

  assign stall          = (hit1 && rd_reg1 != ZERO_REG) || (hit2 && rd_reg2 != ZERO_REG);
  assign idle           = alu_empty && mem_empty && !regwrite_q;
  assign regWrite       = regwrite_q;
  assign write_reg      = write_reg_q;
  assign write_data     = write_data_q;
  assign byteOperations = byte_q;
  assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: each task drives one scenario and
// compares against hand-computed values; strobes are logged at the falling edge.
module tb_regfile_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          is_byte;
  } strobe_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          alu_valid = 1'b0, alu_byte = 1'b0, mem_valid = 1'b0, mem_byte = 1'b0;
  logic [AW-1:0] alu_reg = '0, mem_reg = '0, rd_reg1 = '0, rd_reg2 = '0;
  logic [DW-1:0] alu_data = '0, mem_data = '0;
  logic          alu_ready, mem_ready, regWrite, byteOperations, stall, idle;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [15:0]   wr_count;

  int      n_checks = 0;
  int      n_fail = 0;
  strobe_t log_q[$];

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg),
    .alu_data(alu_data), .alu_byte(alu_byte),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg),
    .mem_data(mem_data), .mem_byte(mem_byte),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .regWrite(regWrite), .write_reg(write_reg), .write_data(write_data),
    .byteOperations(byteOperations), .stall(stall), .idle(idle), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && regWrite) log_q.push_back('{write_reg, write_data, byteOperations});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 1'b0; mem_valid = 1'b0; flush = 1'b0;
    alu_byte = 1'b0;  mem_byte = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && !idle; i++) step();
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++; $display("FAIL %s_idle_timeout: idle=%0b expected 1 within 40 cycles", tag, idle);
    end
  endtask

  // Contested pair right after a flush or reset: ALU must win first.
  task automatic check_alu_first(input string tag);
    alu_valid = 1'b1; alu_reg = 5'd22; alu_data = 32'h220;
    mem_valid = 1'b1; mem_reg = 5'd23; mem_data = 32'h230;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    step();
    n_checks++;
    if (regWrite !== 1'b1 || write_reg !== 5'd22) begin
      n_fail++; $display("FAIL %s_first_grant: regWrite=%0b reg=%0d expected 1/22", tag, regWrite, write_reg);
    end
    step();
    n_checks++;
    if (regWrite !== 1'b1 || write_reg !== 5'd23) begin
      n_fail++; $display("FAIL %s_second_grant: regWrite=%0b reg=%0d expected 1/23", tag, regWrite, write_reg);
    end
    wait_idle(tag);
  endtask

  task automatic test_reset();
    clear_inputs();
    rd_reg1 = 5'd5; rd_reg2 = 5'd9;
    #3;
    n_checks++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: alu=%0b mem=%0b expected 0/0", alu_ready, mem_ready);
    end
    n_checks++;
    if (regWrite !== 1'b0 || write_reg !== '0 || write_data !== '0 || byteOperations !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: rw=%0b reg=%0h data=%0h byte=%0b expected all 0",
                         regWrite, write_reg, write_data, byteOperations);
    end
    n_checks++;
    if (wr_count !== 16'd0 || stall !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL reset_status: cnt=%0d stall=%0b idle=%0b expected 0/0/1", wr_count, stall, idle);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b1 || idle !== 1'b1) begin
      n_fail++; $display("FAIL release_ready: alu=%0b mem=%0b idle=%0b expected 1/1/1", alu_ready, mem_ready, idle);
    end
  endtask

  task automatic test_single_write();
    int base_log;
    base_log = log_q.size();
    rd_reg1 = '0; rd_reg2 = '0;
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h12345678; alu_byte = 1'b0;
    step();
    alu_valid = 1'b0;
    n_checks++;
    if (regWrite !== 1'b0) begin
      n_fail++; $display("FAIL single_early: regWrite=%0b expected 0 one edge after accept", regWrite);
    end
    step();
    n_checks++;
    if (regWrite !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'h12345678 || byteOperations !== 1'b0) begin
      n_fail++; $display("FAIL single_strobe: rw=%0b reg=%0d data=%0h byte=%0b expected 1/5/12345678/0",
                         regWrite, write_reg, write_data, byteOperations);
    end
    step();
    n_checks++;
    if (regWrite !== 1'b0 || wr_count !== 16'd1 || idle !== 1'b1) begin
      n_fail++; $display("FAIL single_after: rw=%0b cnt=%0d idle=%0b expected 0/1/1", regWrite, wr_count, idle);
    end
    n_checks++;
    if (log_q.size() !== base_log + 1) begin
      n_fail++; $display("FAIL single_pulse_count: strobes=%0d expected %0d", log_q.size() - base_log, 1);
    end
  endtask

  task automatic test_alternate();
    int      base_log, ai, mi;
    logic    a_acc, m_acc;
    strobe_t exp;
    do_reset();
    base_log = log_q.size();
    ai = 0; mi = 0;
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hA0; alu_byte = 1'b0;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'hB0; mem_byte = 1'b1;
    for (int cyc = 0; cyc < 60 && (ai < 4 || mi < 4); cyc++) begin
      a_acc = alu_valid && alu_ready;
      m_acc = mem_valid && mem_ready;
      step();
      if (a_acc) begin
        ai++;
        if (ai < 4) alu_data = 32'hA0 + DW'(ai); else alu_valid = 1'b0;
      end
      if (m_acc) begin
        mi++;
        if (mi < 4) mem_data = 32'hB0 + DW'(mi); else mem_valid = 1'b0;
      end
    end
    clear_inputs();
    wait_idle("alternate");
    n_checks++;
    if (log_q.size() !== base_log + 8 || wr_count !== 16'd8) begin
      n_fail++; $display("FAIL alternate_total: strobes=%0d cnt=%0d expected 8/8", log_q.size() - base_log, wr_count);
    end
    for (int k = 0; k < 8; k++) begin
      exp = (k % 2 == 0) ? '{5'd3, 32'hA0 + DW'(k / 2), 1'b0} : '{5'd4, 32'hB0 + DW'(k / 2), 1'b1};
      n_checks++;
      if (base_log + k >= log_q.size() || log_q[base_log + k] !== exp) begin
        n_fail++; $display("FAIL alternate_order[%0d]: got %0h expected %0h", k,
                           (base_log + k < log_q.size()) ? log_q[base_log + k] : '0, exp);
      end
    end
  endtask

  task automatic test_back_pressure();
    int      base_log, j;
    logic [15:0] base_cnt;
    flush = 1'b1;
    step();
    flush = 1'b0;
    base_log = log_q.size(); base_cnt = wr_count;
    alu_valid = 1'b1; alu_reg = 5'd3;  alu_data = 32'h33;  alu_byte = 1'b0;
    mem_valid = 1'b1; mem_reg = 5'd10; mem_data = 32'h100; mem_byte = 1'b0;
    n_checks++;
    if (mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready0: mem_ready=%0b expected 1", mem_ready);
    end
    step();
    mem_reg = 5'd11; mem_data = 32'h101;
    n_checks++;
    if (mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready1: mem_ready=%0b expected 1", mem_ready);
    end
    step();
    mem_reg = 5'd12; mem_data = 32'h102;
    n_checks++;
    if (mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: mem_ready=%0b expected 0 after two accepts", mem_ready);
    end
    step();
    n_checks++;
    if (mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_freed: mem_ready=%0b expected 1 after pop", mem_ready);
    end
    step();
    clear_inputs();
    wait_idle("bp");
    n_checks++;
    if (log_q.size() !== base_log + 6 || wr_count !== base_cnt + 16'd6) begin
      n_fail++; $display("FAIL bp_total: strobes=%0d cnt_delta=%0d expected 6/6",
                         log_q.size() - base_log, wr_count - base_cnt);
    end
    j = 0;
    for (int k = base_log; k < log_q.size(); k++) begin
      if (log_q[k].rd >= 5'd10) begin
        n_checks++;
        if (log_q[k].rd !== 5'd10 + AW'(j) || log_q[k].data !== 32'h100 + DW'(j)) begin
          n_fail++; $display("FAIL bp_mem_order[%0d]: got reg %0d data %0h expected %0d/%0h",
                             j, log_q[k].rd, log_q[k].data, 10 + j, 32'h100 + j);
        end
        j++;
      end
    end
    n_checks++;
    if (j !== 3) begin
      n_fail++; $display("FAIL bp_mem_strobes: got %0d expected 3", j);
    end
  endtask

  task automatic test_reg_zero();
    int          base_log;
    logic [15:0] base_cnt;
    base_log = log_q.size(); base_cnt = wr_count;
    rd_reg1 = '0; rd_reg2 = '0;
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFFFFFF; alu_byte = 1'b1;
    step();
    alu_valid = 1'b0;
    n_checks++;
    if (regWrite !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL r0_queued: rw=%0b stall=%0b expected 0/0", regWrite, stall);
    end
    step();
    n_checks++;
    if (regWrite !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'hFFFFFFFF || byteOperations !== 1'b1) begin
      n_fail++; $display("FAIL r0_stage: rw=%0b reg=%0d data=%0h byte=%0b expected 0/0/ffffffff/1",
                         regWrite, write_reg, write_data, byteOperations);
    end
    step();
    n_checks++;
    if (wr_count !== base_cnt || idle !== 1'b1 || log_q.size() !== base_log) begin
      n_fail++; $display("FAIL r0_after: cnt=%0d idle=%0b strobes=%0d expected %0d/1/0",
                         wr_count, idle, log_q.size() - base_log, base_cnt);
    end
  endtask

  task automatic test_stall();
    rd_reg1 = 5'd7; rd_reg2 = 5'd0;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_empty: stall=%0b expected 0", stall);
    end
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h77;
    step();
    alu_valid = 1'b0;
    n_checks++;
    if (stall !== 1'b1 || regWrite !== 1'b0) begin
      n_fail++; $display("FAIL stall_queued: stall=%0b rw=%0b expected 1/0", stall, regWrite);
    end
    rd_reg1 = 5'd8;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_other_reg: stall=%0b expected 0", stall);
    end
    rd_reg1 = 5'd0; rd_reg2 = 5'd7;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL stall_port2: stall=%0b expected 1", stall);
    end
    rd_reg1 = 5'd7; rd_reg2 = 5'd0;
    step();
    n_checks++;
    if (stall !== 1'b1 || regWrite !== 1'b1) begin
      n_fail++; $display("FAIL stall_strobe: stall=%0b rw=%0b expected 1/1", stall, regWrite);
    end
    step();
    n_checks++;
    if (stall !== 1'b0 || regWrite !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: stall=%0b rw=%0b expected 0/0", stall, regWrite);
    end
    rd_reg1 = '0;
  endtask

  task automatic test_flush();
    int          base_log;
    logic [15:0] base_cnt;
    logic        seen;
    base_log = log_q.size(); base_cnt = wr_count;
    alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'h200;
    mem_valid = 1'b1; mem_reg = 5'd21; mem_data = 32'h210; mem_byte = 1'b0;
    step();
    alu_data = 32'h201; mem_data = 32'h211;
    flush = 1'b1;
    step();
    clear_inputs();
    n_checks++;
    if (regWrite !== 1'b0 || idle !== 1'b1 || wr_count !== base_cnt) begin
      n_fail++; $display("FAIL flush_edge: rw=%0b idle=%0b cnt=%0d expected 0/1/%0d", regWrite, idle, wr_count, base_cnt);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (regWrite) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || log_q.size() !== base_log) begin
      n_fail++; $display("FAIL flush_quiet: strobe_seen=%0b strobes=%0d expected 0/0", seen, log_q.size() - base_log);
    end
    check_alu_first("flush");
  endtask

  task automatic test_reset_mid();
    int base_log;
    base_log = log_q.size();
    alu_valid = 1'b1; alu_reg = 5'd24; alu_data = 32'h240;
    mem_valid = 1'b1; mem_reg = 5'd25; mem_data = 32'h250;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    clear_inputs();
    n_checks++;
    if (regWrite !== 1'b0 || alu_ready !== 1'b0 || mem_ready !== 1'b0 || wr_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_async: rw=%0b ar=%0b mr=%0b cnt=%0d expected 0/0/0/0",
                         regWrite, alu_ready, mem_ready, wr_count);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (idle !== 1'b1 || log_q.size() !== base_log) begin
      n_fail++; $display("FAIL rst_mid_lost: idle=%0b strobes=%0d expected 1/0", idle, log_q.size() - base_log);
    end
    check_alu_first("rst_mid");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_alternate();
    test_back_pressure();
    test_reg_zero();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
